button_gesture_queue: RTL and testbench

//  Consumes the 1-cycle press pulses (b1_out/b2_out) from the button controller.

---
 rtl/button_gesture_queue.sv | 130 +++++++++++++
 tb/tb_button_gesture_queue.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_gesture_queue.sv
// Turns button press pulses into {btn, type} gesture events and queues them for the game logic.
// Define BTN_DOUBLE_TAP_EN for SINGLE/DOUBLE classification; without it every press is a SINGLE.
module button_gesture_queue #(
  parameter int DBL_WINDOW = 12_500_000,
  parameter int CNT_W      = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        b1_pulse,
  input  logic                        b2_pulse,
  output logic                        ev_valid,
  output logic [1:0]                  ev_data,
  input  logic                        ev_ready,
  output logic [$clog2(FIFO_DEPTH):0] ev_count,
  output logic                        overflow
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || DBL_WINDOW < 1 || CNT_W < 1 ||
      longint'(DBL_WINDOW - 1) >= (longint'(1) << CNT_W)) begin : g_bad_cfg
    $error("button_gesture_queue: invalid parameter set");
  end

  logic [1:0] pulse;
  logic [1:0] dec_valid;
  logic [1:0] dec_type;

  assign pulse = {b2_pulse, b1_pulse};

`ifdef BTN_DOUBLE_TAP_EN
  typedef enum logic {IDLE, WAIT2} tap_state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DBL_WINDOW - 1);

  for (genvar i = 0; i < 2; i++) begin : g_tap
    tap_state_t       state;
    logic [CNT_W-1:0] cnt;

    // The window closes at LAST, so the increment never runs past it.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (pulse[i]) begin
              state <= WAIT2;
              cnt   <= '0;
            end
          end
          WAIT2: begin
            if (pulse[i] || cnt == LAST) state <= IDLE;
            else                         cnt   <= cnt + 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end

    assign dec_valid[i] = (state == WAIT2) && (pulse[i] || cnt == LAST);
    assign dec_type[i]  = (state == WAIT2) && pulse[i];
  end
`else
  assign dec_valid = pulse;
  assign dec_type  = 2'b00;
`endif

  logic [1:0]     pend_valid;
  logic [1:0]     pend_type;
  logic [1:0]     grant;
  logic [1:0]     push_data;
  logic           full;
  logic           empty;
  logic           pop;
  logic           push;
  logic           can_push;
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  logic [1:0]     mem [FIFO_DEPTH];

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign ev_valid  = !empty;
  assign pop       = ev_valid && ev_ready;
  assign can_push  = !full || pop;
  assign grant[0]  = pend_valid[0] && can_push;
  assign grant[1]  = pend_valid[1] && !pend_valid[0] && can_push;
  assign push      = |grant;
  assign push_data = grant[0] ? {1'b0, pend_type[0]} : {1'b1, pend_type[1]};
  assign ev_data   = mem[rd_ptr[PTR_W-1:0]];
  assign ev_count  = wr_ptr - rd_ptr;

  // A slot being granted this edge is free for a new decision on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_valid <= '0;
      pend_type  <= '0;
      overflow   <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (grant[i]) pend_valid[i] <= 1'b0;
        if (dec_valid[i]) begin
          if (pend_valid[i] && !grant[i]) begin
            overflow <= 1'b1;
          end else begin
            pend_valid[i] <= 1'b1;
            pend_type[i]  <= dec_type[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) mem[k] <= 2'b00;
    end else begin
      if (push) begin
        mem[wr_ptr[PTR_W-1:0]] <= push_data;
        wr_ptr                 <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_button_gesture_queue.sv
// Self-checking bench for button_gesture_queue: vector table for FIFO fill/overflow, scoreboard for drained events.
// Expected latencies follow BTN_DOUBLE_TAP_EN when it is defined for the build.
module tb_button_gesture_queue;
  localparam int DBL_WINDOW = 8;
  localparam int CNT_W      = 4;
  localparam int FIFO_DEPTH = 4;
`ifdef BTN_DOUBLE_TAP_EN
  localparam int L = DBL_WINDOW;
`else
  localparam int L = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       b1_pulse;
  logic       b2_pulse;
  logic       ev_valid;
  logic [1:0] ev_data;
  logic       ev_ready;
  logic [2:0] ev_count;
  logic       overflow;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  int exp_d;

  typedef struct {
    logic b1;
    logic b2;
    int   exp_count;
    logic exp_ovf;
  } gesture_vec_t;

  gesture_vec_t vecs [7];
  int           drain_counts [6];

  button_gesture_queue #(
    .DBL_WINDOW(DBL_WINDOW),
    .CNT_W(CNT_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .b1_pulse(b1_pulse),
    .b2_pulse(b2_pulse),
    .ev_valid(ev_valid),
    .ev_data(ev_data),
    .ev_ready(ev_ready),
    .ev_count(ev_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Drives one cycle of pulses, lets the edge sample them, then drops the pulses.
  task automatic applyStimulus(input logic b1, input logic b2, input logic rdy);
    b1_pulse = b1;
    b2_pulse = b2;
    ev_ready = rdy;
    tick();
    b1_pulse = 1'b0;
    b2_pulse = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) tick();
    checkOutput(name, exp_q.size(), 0);
    checkOutput({name, "_count"}, int'(ev_count), 0);
  endtask

  // Inputs only change just after a rising edge, so at the falling edge a pop is already decided.
  always @(negedge clk) begin
    if (!reset && ev_valid && ev_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL scoreboard_unexpected: got event %0d expected none", ev_data);
      end else begin
        exp_d = exp_q.pop_front();
        checkOutput("scoreboard_data", int'(ev_data), exp_d);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit seen;

    vecs = '{
      '{1'b1, 1'b0, 1, 1'b0},
      '{1'b0, 1'b1, 2, 1'b0},
      '{1'b1, 1'b0, 3, 1'b0},
      '{1'b0, 1'b1, 4, 1'b0},
      '{1'b1, 1'b0, 4, 1'b0},
      '{1'b0, 1'b1, 4, 1'b0},
      '{1'b1, 1'b0, 4, 1'b1}
    };
    drain_counts = '{4, 4, 3, 2, 1, 0};

    reset    = 1'b1;
    b1_pulse = 1'b0;
    b2_pulse = 1'b0;
    ev_ready = 1'b0;
    repeat (2) tick();
    checkOutput("reset_valid", int'(ev_valid), 0);
    checkOutput("reset_data", int'(ev_data), 0);
    checkOutput("reset_count", int'(ev_count), 0);
    checkOutput("reset_overflow", int'(overflow), 0);
    reset = 1'b0;
    tick();

    // Single b1 gesture: visible only on the edge after its decision.
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (L) tick();
    checkOutput("t1_valid_early", int'(ev_valid), 0);
    tick();
    checkOutput("t1_valid", int'(ev_valid), 1);
    checkOutput("t1_data", int'(ev_data), 0);
    checkOutput("t1_count", int'(ev_count), 1);
    exp_q.push_back(0);
    ev_ready = 1'b1;
    tick();
    checkOutput("t1_count_after_pop", int'(ev_count), 0);
    checkOutput("t1_valid_after_pop", int'(ev_valid), 0);

    // b2 taps at cycles 0 and 5.
`ifdef BTN_DOUBLE_TAP_EN
    exp_q.push_back(3);
`else
    exp_q.push_back(2);
    exp_q.push_back(2);
`endif
    applyStimulus(1'b0, 1'b1, 1'b1);
    repeat (4) tick();
    applyStimulus(1'b0, 1'b1, 1'b1);
    repeat (L + 6) tick();
    waitDrain("t2_drain");

    // Both buttons decide together: b1 enters first and the head holds while not ready.
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (L + 1) tick();
    checkOutput("t3_count1", int'(ev_count), 1);
    checkOutput("t3_data1", int'(ev_data), 0);
    tick();
    checkOutput("t3_count2", int'(ev_count), 2);
    checkOutput("t3_data_hold", int'(ev_data), 0);
    exp_q.push_back(0);
    exp_q.push_back(2);
    ev_ready = 1'b1;
    waitDrain("t3_drain");

    // Fill FIFO and both pending registers, then overflow on a 7th b1 gesture.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].b1, vecs[i].b2, 1'b0);
      repeat (L + 1) tick();
      checkOutput($sformatf("t4_count_%0d", i), int'(ev_count), vecs[i].exp_count);
      checkOutput($sformatf("t4_ovf_%0d", i), int'(overflow), int'(vecs[i].exp_ovf));
    end
    for (int i = 0; i < 6; i++) exp_q.push_back((i % 2 == 0) ? 0 : 2);
    ev_ready = 1'b1;
    foreach (drain_counts[i]) begin
      tick();
      checkOutput($sformatf("t5_drain_count_%0d", i), int'(ev_count), drain_counts[i]);
    end
    waitDrain("t5_drain");
    checkOutput("t5_ovf_sticky", int'(overflow), 1);

    // Reset while a gesture is in flight discards it and clears the sticky flag.
    ev_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    if (L >= 3) repeat (2) tick();
    reset = 1'b1;
    #1;
    checkOutput("t6_rst_valid", int'(ev_valid), 0);
    checkOutput("t6_rst_data", int'(ev_data), 0);
    checkOutput("t6_rst_count", int'(ev_count), 0);
    checkOutput("t6_rst_overflow", int'(overflow), 0);
    tick();
    reset    = 1'b0;
    ev_ready = 1'b1;
    seen     = 1'b0;
    repeat (L + 4) begin
      tick();
      if (ev_valid) seen = 1'b1;
    end
    checkOutput("t6_no_event", int'(seen), 0);

    // b1 taps at cycles 0 and 5.
`ifdef BTN_DOUBLE_TAP_EN
    exp_q.push_back(1);
`else
    exp_q.push_back(0);
    exp_q.push_back(0);
`endif
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (4) tick();
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (L + 6) tick();
    waitDrain("t7_drain");
    checkOutput("t7_overflow", int'(overflow), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
